// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Ratio 1 is not a legal divide and is promoted to 2 wherever a ratio enters a channel.
package clk_div_pkg;

  localparam int unsigned CH_IDX_W = 4;
  localparam int unsigned CH_SLOTS = 1 << CH_IDX_W;

  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d == 32'd1) ? 32'd2 : d;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active ratio, single pending-ratio slot and registered
// clk/tick outputs. Ratio changes land only on a period boundary, so no runt pulses.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(clamp_div(32'(DEF_DIV)));

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] div_nx;
  logic [DIV_W-1:0] hi_m1;
  logic             wrap;

  always_comb begin
    div_nx     = pend_q ? pend_div_q : div_q;
    hi_m1      = (div_q >> 1) - DIV_W'(1);
    wrap       = (div_q != '0) && (cnt_q == div_q - DIV_W'(1));
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;

    // A write is only accepted while the slot is empty, so it never collides with a take.
    if (wr_i) begin
      pend_d     = 1'b1;
      pend_div_d = DIV_W'(clamp_div(32'(wr_div_i)));
    end

    // Sync and the stopped state share handling: park at cnt=0/low and adopt any pending ratio.
    if (sync_i || (div_q == '0)) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_q) begin
        div_d  = pend_div_q;
        pend_d = 1'b0;
      end
    end else if (wrap) begin
      cnt_d  = '0;
      div_d  = div_nx;
      clk_d  = (div_nx != '0);
      tick_d = (div_nx != '0);
      if (pend_q) begin
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
      if (cnt_q == hi_m1) begin
        clk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      div_q      <= RST_DIV;
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

  assign pend_o = pend_q;
  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// NCH-channel programmable clock divider with a valid/ready ratio config port.
// Define CLK_DIV_SYNC_EN to add sync_in, which realigns all channel phases.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic [NCH-1:0]      clk_out,
  output logic [NCH-1:0]      tick
`ifdef CLK_DIV_SYNC_EN
  ,
  input  logic                sync_in
`endif
);

  logic [NCH-1:0]      pend;
  logic [NCH-1:0]      wr;
  logic [CH_SLOTS-1:0] pend_pad;
  logic                sync;

`ifdef CLK_DIV_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  // Unimplemented channel slots read as empty, so writes to them are accepted and dropped.
  always_comb begin
    pend_pad          = '0;
    pend_pad[NCH-1:0] = pend;
  end

  assign cfg_ready = ~pend_pad[cfg_ch];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr[i] = cfg_valid & cfg_ready & (cfg_ch == CH_IDX_W'(i));

    clk_div_chan #(
      .DIV_W  (DIV_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk_i   (clk_in),
      .rst_ni  (rst_n),
      .sync_i  (sync),
      .wr_i    (wr[i]),
      .wr_div_i(cfg_div),
      .pend_o  (pend[i]),
      .clk_o   (clk_out[i]),
      .tick_o  (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (DEF_DIV=4): vector table plus per-channel waveform sequences.
// Extra sync_in checks are compiled when CLK_DIV_SYNC_EN is defined.
module tb_clk_div_multi;

  localparam int unsigned NCH     = 4;
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned DEF_DIV = 4;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
`ifdef CLK_DIV_SYNC_EN
  logic             sync_in;
  logic [NCH-1:0]   cap_clk [24];
  logic [NCH-1:0]   cap_tick[24];
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  clk_div_multi #(
    .NCH    (NCH),
    .DIV_W  (DIV_W),
    .DEF_DIV(DEF_DIV)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .clk_out  (clk_out),
    .tick     (tick)
`ifdef CLK_DIV_SYNC_EN
    ,
    .sync_in  (sync_in)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic [3:0]  ch;
    logic [15:0] div;
    logic [3:0]  e_clk;
    logic [3:0]  e_tick;
    logic        e_rdy;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] ch,
                              input logic [15:0] d, input logic [3:0] c,
                              input logic [3:0] t, input logic rdy);
    vec_t x;
    x.rst_n  = r;
    x.vld    = v;
    x.ch     = ch;
    x.div    = d;
    x.e_clk  = c;
    x.e_tick = t;
    x.e_rdy  = rdy;
    return x;
  endfunction

  function automatic logic bit_of(input string s, input int i);
    return s[i] == "1";
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Per edge: drive valid, check pre-edge ready, clock, check channel clk/tick.
  task automatic seq(input int ch, input int n, input logic [DIV_W-1:0] div,
                     input string vld, input string rdy, input string cp,
                     input string tp, input string nm);
    cfg_ch  = 4'(ch);
    cfg_div = div;
    for (int i = 0; i < n; i++) begin
      cfg_valid = bit_of(vld, i);
      #1;
      chk($sformatf("%s ready[%0d]", nm, i), 32'(cfg_ready), 32'(bit_of(rdy, i)));
      @(posedge clk_in);
      #1;
      chk($sformatf("%s clk[%0d]", nm, i), 32'(clk_out[ch]), 32'(bit_of(cp, i)));
      chk($sformatf("%s tick[%0d]", nm, i), 32'(tick[ch]), 32'(bit_of(tp, i)));
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wr1(input int ch, input logic [DIV_W-1:0] div, input string nm);
    cfg_ch    = 4'(ch);
    cfg_div   = div;
    cfg_valid = 1'b1;
    #1;
    chk($sformatf("%s ready", nm), 32'(cfg_ready), 32'd1);
    @(posedge clk_in);
    #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1, "timeout");
  end

  initial begin
    string p_clk;
    string p_tck;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
`ifdef CLK_DIV_SYNC_EN
    sync_in   = 1'b0;
`endif

    // Reset then the first 12 edges at DEF_DIV=4; row 10 writes the nonexistent channel 4.
    tbl[0]  = mk(1'b0, 1'b0, 4'd0, 16'd0, 4'h0, 4'h0, 1'b1);
    tbl[1]  = mk(1'b1, 1'b0, 4'd0, 16'd0, 4'h0, 4'h0, 1'b1);
    tbl[2]  = mk(1'b1, 1'b0, 4'd0, 16'd0, 4'h0, 4'h0, 1'b1);
    tbl[3]  = mk(1'b1, 1'b0, 4'd0, 16'd0, 4'h0, 4'h0, 1'b1);
    tbl[4]  = mk(1'b1, 1'b0, 4'd0, 16'd0, 4'hF, 4'hF, 1'b1);
    tbl[5]  = mk(1'b1, 1'b0, 4'd0, 16'd0, 4'hF, 4'h0, 1'b1);
    tbl[6]  = mk(1'b1, 1'b0, 4'd0, 16'd0, 4'h0, 4'h0, 1'b1);
    tbl[7]  = mk(1'b1, 1'b0, 4'd0, 16'd0, 4'h0, 4'h0, 1'b1);
    tbl[8]  = mk(1'b1, 1'b0, 4'd0, 16'd0, 4'hF, 4'hF, 1'b1);
    tbl[9]  = mk(1'b1, 1'b0, 4'd0, 16'd0, 4'hF, 4'h0, 1'b1);
    tbl[10] = mk(1'b1, 1'b1, 4'd4, 16'd7, 4'h0, 4'h0, 1'b1);
    tbl[11] = mk(1'b1, 1'b0, 4'd4, 16'd0, 4'h0, 4'h0, 1'b1);
    tbl[12] = mk(1'b1, 1'b0, 4'd0, 16'd0, 4'hF, 4'hF, 1'b1);

    @(posedge clk_in);
    #1;
    for (int i = 0; i < 13; i++) begin
      rst_n     = tbl[i].rst_n;
      cfg_valid = tbl[i].vld;
      cfg_ch    = tbl[i].ch;
      cfg_div   = tbl[i].div;
      #1;
      chk($sformatf("tbl%0d ready", i), 32'(cfg_ready), 32'(tbl[i].e_rdy));
      @(posedge clk_in);
      #1;
      chk($sformatf("tbl%0d clk_out", i), 32'(clk_out), 32'(tbl[i].e_clk));
      chk($sformatf("tbl%0d tick", i), 32'(tick), 32'(tbl[i].e_tick));
    end
    cfg_valid = 1'b0;

    // ch1 -> 5 mid-period: old period finishes, then 2 high / 3 low.
    seq(1, 14, 16'd5, "10000000000000", "10001111111111",
        "10011000110001", "00010000100001", "ch1 div5");
    // ch2 -> 0 during high phase: period completes, then stays low.
    seq(2, 10, 16'd0, "0010000000", "1110001111",
        "0110000000", "0100000000", "ch2 stop");
    // ch2 -> 3 while stopped: taken next edge, first rise 3 edges later.
    seq(2, 11, 16'd3, "10000000000", "10111111111",
        "00001001001", "00001001001", "ch2 div3");
    // ch3 -> 1 on its wrap edge: old ratio rules that wrap, then period 2.
    seq(3, 10, 16'd1, "1000000000", "1000011111",
        "1100101010", "1000101010", "ch3 div1");
    // ch0 back-to-back: first write lands on a wrap edge, second stalls until applied.
    seq(0, 3, 16'd6, "001", "111", "001", "001", "ch0 wrap write");
    seq(0, 13, 16'd2, "1111100000000", "0000100000111",
        "1001110001010", "0001000001010", "ch0 stall");

    // Pending write then reset: pending lost, all channels back to DEF_DIV.
    wr1(1, 16'd7, "pre-reset wr");
    rst_n = 1'b0;
    @(posedge clk_in);
    #1;
    chk("reset clk_out", 32'(clk_out), 32'd0);
    chk("reset tick", 32'(tick), 32'd0);
    rst_n  = 1'b1;
    cfg_ch = 4'd1;
    #1;
    chk("reset ch1 ready", 32'(cfg_ready), 32'd1);
    p_clk = "00011001";
    p_tck = "00010001";
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_in);
      #1;
      chk($sformatf("post-reset clk[%0d]", i), 32'(clk_out), bit_of(p_clk, i) ? 32'hF : 32'h0);
      chk($sformatf("post-reset tick[%0d]", i), 32'(tick), bit_of(p_tck, i) ? 32'hF : 32'h0);
    end

`ifdef CLK_DIV_SYNC_EN
    // ch1 -> 6 (phase offset from ch0), ch2 -> 3 left pending, then sync pulse.
    wr1(1, 16'd6, "sync ch1 wr");
    repeat (3) @(posedge clk_in);
    #1;
    wr1(2, 16'd3, "sync ch2 wr");
    sync_in = 1'b1;
    @(posedge clk_in);
    #1;
    sync_in = 1'b0;
    chk("sync clk_out", 32'(clk_out), 32'd0);
    chk("sync tick", 32'(tick), 32'd0);
    cfg_ch = 4'd2;
    #1;
    chk("sync ch2 ready", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk_in);
      #1;
      cap_clk[i]  = clk_out;
      cap_tick[i] = tick;
    end
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("sync ch0 clk[%0d]", i), 32'(cap_clk[i][0]),
          32'(bit_of("000110011001100110011001", i)));
      chk($sformatf("sync ch0 tick[%0d]", i), 32'(cap_tick[i][0]),
          32'(bit_of("000100010001000100010001", i)));
      chk($sformatf("sync ch1 clk[%0d]", i), 32'(cap_clk[i][1]),
          32'(bit_of("000001110001110001110001", i)));
      chk($sformatf("sync ch1 tick[%0d]", i), 32'(cap_tick[i][1]),
          32'(bit_of("000001000001000001000001", i)));
      chk($sformatf("sync ch2 clk[%0d]", i), 32'(cap_clk[i][2]),
          32'(bit_of("001001001001001001001001", i)));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
